// File: rtl/spi_frame_loader.sv
// spi_frame_loader: SPI-fed double-buffered 8x8 two-color frame source.
// Frames commit to a pending buffer and swap in on the scan frame boundary.
module spi_frame_loader #(
    parameter logic [63:0] BLANK       = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sck,
    input  logic        sdi,
    input  logic        cs_n,
    input  logic        frame_sync,
    output logic [63:0] x_matrix,
    output logic [63:0] y_matrix,
    output logic        frame_pending,
    output logic        load_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sy;
    logic [SYNC_STAGES-1:0] sdi_sy;
    logic [SYNC_STAGES-1:0] cs_sy;
    logic                   sck_d;
    logic                   cs_d;

    logic sck_s;
    logic sdi_s;
    logic cs_s;
    logic sck_rise;
    logic cs_fall;
    logic cs_rise;

    state_t         state;
    logic [127:0]   shift_reg;
    logic [7:0]     bit_cnt;
    logic           ovf;
    logic [63:0]    pend_x;
    logic [63:0]    pend_y;

    assign sck_s    = sck_sy[SYNC_STAGES-1];
    assign sdi_s    = sdi_sy[SYNC_STAGES-1];
    assign cs_s     = cs_sy[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign cs_rise  = cs_s & ~cs_d;

    // Pin synchronizers plus one delayed copy for edge detection; cs_n
    // resets high and sck low so release never fakes an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sy <= '0;
            sdi_sy <= '0;
            cs_sy  <= '1;
            sck_d  <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sck_sy <= {sck_sy[SYNC_STAGES-2:0], sck};
            sdi_sy <= {sdi_sy[SYNC_STAGES-2:0], sdi};
            cs_sy  <= {cs_sy[SYNC_STAGES-2:0], cs_n};
            sck_d  <= sck_s;
            cs_d   <= cs_s;
        end
    end

    // Transaction FSM, pending buffer and display swap; a commit in the
    // same cycle as a swap lands after the swap has taken the old frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            ovf           <= 1'b0;
            pend_x        <= BLANK;
            pend_y        <= BLANK;
            x_matrix      <= BLANK;
            y_matrix      <= BLANK;
            frame_pending <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            load_err <= 1'b0;

            if (frame_sync && frame_pending) begin
                x_matrix      <= pend_x;
                y_matrix      <= pend_y;
                frame_pending <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        ovf     <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        if (bit_cnt == 8'd128) begin
                            ovf <= 1'b1;
                        end else begin
                            shift_reg <= {shift_reg[126:0], sdi_s};
                            bit_cnt   <= bit_cnt + 8'd1;
                        end
                    end
                    if (cs_rise) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (bit_cnt == 8'd128 && !ovf) begin
                        pend_x        <= shift_reg[127:64];
                        pend_y        <= shift_reg[63:0];
                        frame_pending <= 1'b1;
                    end else begin
                        load_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_loader.sv
// tb_spi_frame_loader: directed and random SPI frames checked against
// a frame-level model of the pending buffer and displayed matrices.
module tb_spi_frame_loader;

    localparam logic [63:0] BLANK = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int HALF = 4;

    logic        clk;
    logic        reset;
    logic        sck;
    logic        sdi;
    logic        cs_n;
    logic        frame_sync;
    logic [63:0] x_matrix;
    logic [63:0] y_matrix;
    logic        frame_pending;
    logic        load_err;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;

    logic [63:0] m_x;
    logic [63:0] m_y;
    logic [63:0] m_px;
    logic [63:0] m_py;
    logic        m_pend;
    int          m_err;

    spi_frame_loader #(
        .BLANK       (BLANK),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sck           (sck),
        .sdi           (sdi),
        .cs_n          (cs_n),
        .frame_sync    (frame_sync),
        .x_matrix      (x_matrix),
        .y_matrix      (y_matrix),
        .frame_pending (frame_pending),
        .load_err      (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count every cycle load_err is high
    always @(posedge clk) begin
        if (reset && load_err) err_seen <= err_seen + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"}, x_matrix, m_x);
        chk({tag, ".y"}, y_matrix, m_y);
        chk({tag, ".pend"}, 64'(frame_pending), 64'(m_pend));
        chk({tag, ".errs"}, 64'(err_seen), 64'(m_err));
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_x    = BLANK;
        m_y    = BLANK;
        m_px   = BLANK;
        m_py   = BLANK;
        m_pend = 1'b0;
    endtask

    task automatic model_swap();
        if (m_pend) begin
            m_x    = m_px;
            m_y    = m_py;
            m_pend = 1'b0;
        end
    endtask

    task automatic pulse_sync();
        step(1);
        frame_sync = 1'b1;
        step(1);
        frame_sync = 1'b0;
        model_swap();
        step(1);
    endtask

    // Send n bits of d MSB first; sync_chk lines frame_sync up with the
    // commit cycle; abort_at >= 0 resets the DUT after that many bits.
    task automatic xfer(input logic [129:0] d, input int n,
                        input bit sync_chk, input int abort_at);
        step(1);
        cs_n = 1'b0;
        step(HALF);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                #2 reset = 1'b0;
                step(2);
                cs_n = 1'b1;
                sck  = 1'b0;
                sdi  = 1'b0;
                step(2);
                reset = 1'b1;
                model_reset();
                step(2);
                return;
            end
            sdi = d[n-1-i];
            step(HALF - 1);
            sck = 1'b1;
            step(HALF);
            sck = 1'b0;
            step(1);
        end
        step(HALF);
        cs_n = 1'b1;
        if (sync_chk) begin
            step(3);
            frame_sync = 1'b1;
            step(1);
            frame_sync = 1'b0;
            model_swap();
        end
        if (n == 128) begin
            m_px   = d[127:64];
            m_py   = d[63:0];
            m_pend = 1'b1;
        end else begin
            m_err++;
        end
        step(8);
    endtask

    function automatic logic [129:0] rnd130();
        logic [129:0] r;
        for (int i = 0; i < 130; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    initial begin
        logic [129:0] d;
        int op;
        int n;
        reset = 1'b0;
        sck = 1'b0;
        sdi = 1'b0;
        cs_n = 1'b1;
        frame_sync = 1'b0;
        m_err = 0;
        model_reset();

        #23;
        check_all("reset");
        step(2);
        reset = 1'b1;
        step(3);
        check_all("post_reset");

        xfer({2'b0, 64'hFFBDE7C3C3E7BDFF, 64'hC381387CFCFCF9F3}, 128, 0, -1);
        check_all("nominal_load");
        pulse_sync();
        check_all("nominal_swap");

        xfer(rnd130(), 127, 0, -1);
        check_all("short127");
        xfer(rnd130(), 129, 0, -1);
        check_all("long129");

        xfer({2'b0, 64'h0, 64'h0}, 128, 0, -1);
        xfer({2'b0, 64'h1, 64'h2}, 128, 0, -1);
        check_all("overwrite_pend");
        pulse_sync();
        check_all("overwrite_swap");

        xfer({2'b0, 64'hA5A5_0000_1111_2222, 64'h3333_4444_5555_6666},
             128, 0, -1);
        xfer({2'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210},
             128, 1, -1);
        check_all("collide");
        pulse_sync();
        check_all("collide_next");

        xfer(rnd130(), 128, 1, -1);
        check_all("collide_nopend");
        pulse_sync();
        check_all("collide_nopend_next");

        pulse_sync();
        check_all("idle_sync");

        xfer(rnd130(), 128, 0, 50);
        check_all("mid_reset");
        xfer({2'b0, 64'hDEAD_BEEF_0BAD_F00D, 64'h1234_5678_9ABC_DEF0},
             128, 0, -1);
        check_all("after_reset_load");
        pulse_sync();
        check_all("after_reset_swap");

        for (int it = 0; it < 16; it++) begin
            op = $urandom_range(0, 6);
            d = rnd130();
            case (op)
                0, 1: xfer(d, 128, 0, -1);
                2:    xfer(d, 128, 1, -1);
                3: begin
                    n = $urandom_range(1, 127);
                    xfer(d, n, 0, -1);
                end
                4: begin
                    n = $urandom_range(129, 130);
                    xfer(d, n, 0, -1);
                end
                default: pulse_sync();
            endcase
            check_all($sformatf("rand%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
